// File: rtl/score_keeper.sv
// score_keeper: N-player BCD score keeper with per-player hold-off,
// pause, win detection, game-over state and new-game clear.
module score_keeper #(
    parameter int PLAYERS   = 2,
    parameter int DIGITS    = 2,
    parameter int WIN_SCORE = 11,
    parameter int SATURATE  = 1,
    parameter int HOLDOFF   = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        clear,
    input  logic                        enable,
    input  logic [PLAYERS-1:0]          score_in,
    output logic [PLAYERS*DIGITS*4-1:0] scores,
    output logic [PLAYERS-1:0]          point_pulse,
    output logic [PLAYERS-1:0]          winner,
    output logic                        game_over
);

    localparam int SW = DIGITS * 4;
    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic {
        PLAY = 1'b0,
        OVER = 1'b1
    } state_t;

    function automatic logic [SW-1:0] to_bcd(input int value);
        logic [SW-1:0] r;
        int            v;
        r = '0;
        v = value;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Ripple carry from the units digit; an all-9s value wraps to 0.
    function automatic logic [SW-1:0] bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (v[d*4 +: 4] == 4'd9) begin
                    r[d*4 +: 4] = 4'd0;
                end else begin
                    r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    localparam logic [SW-1:0] WIN_BCD = to_bcd(WIN_SCORE);
    localparam logic [SW-1:0] ALL9    = to_bcd(10 ** DIGITS - 1);
    localparam logic [HW-1:0] HOLD_LD = HW'(HOLDOFF);

    state_t               state_q;
    state_t               state_d;
    logic [PLAYERS-1:0]   prev_q;
    logic [PLAYERS-1:0]   rise;
    logic [PLAYERS-1:0]   accept;
    logic [PLAYERS-1:0]   win_hit;
    logic [PLAYERS-1:0]   pulse_q;
    logic [PLAYERS-1:0]   winner_q;
    logic [SW-1:0]        score_q [PLAYERS];
    logic [SW-1:0]        score_inc [PLAYERS];
    logic [SW-1:0]        score_d [PLAYERS];
    logic [HW-1:0]        hold_q [PLAYERS];

    always_comb begin
        rise    = '0;
        accept  = '0;
        win_hit = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            rise[p]   = score_in[p] & ~prev_q[p];
            accept[p] = rise[p] & enable & (state_q == PLAY)
                      & (hold_q[p] == '0) & ~clear;
            if ((SATURATE != 0) && (score_q[p] == ALL9)) begin
                score_inc[p] = ALL9;
            end else begin
                score_inc[p] = bcd_inc(score_q[p]);
            end
            score_d[p] = accept[p] ? score_inc[p] : score_q[p];
            win_hit[p] = (WIN_SCORE != 0) && accept[p]
                       && (score_inc[p] == WIN_BCD);
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clear always returns to PLAY
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PLAY: begin
                if (!clear && (|win_hit)) begin
                    state_d = OVER;
                end
            end
            OVER: begin
                if (clear) begin
                    state_d = PLAY;
                end
            end
            default: state_d = PLAY;
        endcase
    end

    // Output logic
    always_comb begin
        game_over   = (state_q == OVER);
        point_pulse = pulse_q;
        winner      = winner_q;
        scores      = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            scores[p*SW +: SW] = score_q[p];
        end
    end

    // Edge history starts high so a level held through reset never scores.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q <= '1;
        end else begin
            prev_q <= score_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q  <= '0;
            winner_q <= '0;
            for (int p = 0; p < PLAYERS; p++) begin
                score_q[p] <= '0;
                hold_q[p]  <= '0;
            end
        end else if (clear) begin
            pulse_q  <= '0;
            winner_q <= '0;
            for (int p = 0; p < PLAYERS; p++) begin
                score_q[p] <= '0;
                hold_q[p]  <= '0;
            end
        end else begin
            pulse_q  <= accept;
            winner_q <= winner_q | win_hit;
            for (int p = 0; p < PLAYERS; p++) begin
                score_q[p] <= score_d[p];
                if (accept[p]) begin
                    hold_q[p] <= HOLD_LD;
                end else if (hold_q[p] != '0) begin
                    hold_q[p] <= hold_q[p] - HW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: three configurations driven in parallel,
// checked every cycle against a decimal-arithmetic reference model.
module tb_score_keeper;

    localparam int P  = 2;
    localparam int D  = 2;
    localparam int HO = 4;
    localparam int SW = P * D * 4;
    localparam int MAXV = 99;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         clear = 1'b0;
    logic         enable = 1'b1;
    logic [P-1:0] score_in = 2'b01;

    logic [SW-1:0] sc [3];
    logic [P-1:0]  pp [3];
    logic [P-1:0]  wn [3];
    logic          go [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    score_keeper #(.PLAYERS(P), .DIGITS(D), .WIN_SCORE(11),
                   .SATURATE(1), .HOLDOFF(HO)) u0 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
        .score_in(score_in), .scores(sc[0]), .point_pulse(pp[0]),
        .winner(wn[0]), .game_over(go[0]));

    score_keeper #(.PLAYERS(P), .DIGITS(D), .WIN_SCORE(0),
                   .SATURATE(1), .HOLDOFF(HO)) u1 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
        .score_in(score_in), .scores(sc[1]), .point_pulse(pp[1]),
        .winner(wn[1]), .game_over(go[1]));

    score_keeper #(.PLAYERS(P), .DIGITS(D), .WIN_SCORE(0),
                   .SATURATE(0), .HOLDOFF(HO)) u2 (
        .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
        .score_in(score_in), .scores(sc[2]), .point_pulse(pp[2]),
        .winner(wn[2]), .game_over(go[2]));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain decimal scores, hold-off as cycle distance.
    int           cfg_win [3] = '{11, 0, 0};
    bit           cfg_sat [3] = '{1'b1, 1'b1, 1'b0};
    int           m_score [3][P];
    bit           m_win [3][P];
    bit           m_pulse [3][P];
    bit           m_over [3];
    int           m_last [3][P];
    logic [P-1:0] m_prev;
    int           cyc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_prev = '1;
            cyc    = 0;
            for (int i = 0; i < 3; i++) begin
                m_over[i] = 1'b0;
                for (int p = 0; p < P; p++) begin
                    m_score[i][p] = 0;
                    m_win[i][p]   = 1'b0;
                    m_pulse[i][p] = 1'b0;
                    m_last[i][p]  = -100;
                end
            end
        end else begin
            cyc++;
            for (int i = 0; i < 3; i++) begin
                bit was_over;
                was_over = m_over[i];
                for (int p = 0; p < P; p++) begin
                    bit acc;
                    acc = score_in[p] && !m_prev[p] && enable && !was_over
                        && (cyc - m_last[i][p] > HO) && !clear;
                    m_pulse[i][p] = acc;
                    if (clear) begin
                        m_score[i][p] = 0;
                        m_win[i][p]   = 1'b0;
                        m_last[i][p]  = -100;
                    end else if (acc) begin
                        m_last[i][p] = cyc;
                        if (m_score[i][p] == MAXV) begin
                            m_score[i][p] = cfg_sat[i] ? MAXV : 0;
                        end else begin
                            m_score[i][p] = m_score[i][p] + 1;
                        end
                        if (cfg_win[i] != 0 && m_score[i][p] == cfg_win[i]) begin
                            m_win[i][p] = 1'b1;
                            m_over[i]   = 1'b1;
                        end
                    end
                end
                if (clear) m_over[i] = 1'b0;
            end
            m_prev = score_in;
        end
    end

    function automatic logic [SW-1:0] exp_sc(input int i);
        logic [SW-1:0] r;
        r = '0;
        for (int p = 0; p < P; p++) begin
            int v;
            v = m_score[i][p];
            for (int d = 0; d < D; d++) begin
                r[(p*D + d)*4 +: 4] = 4'(v % 10);
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [P-1:0] exp_pp(input int i);
        logic [P-1:0] r;
        for (int p = 0; p < P; p++) r[p] = m_pulse[i][p];
        return r;
    endfunction

    function automatic logic [P-1:0] exp_wn(input int i);
        logic [P-1:0] r;
        for (int p = 0; p < P; p++) r[p] = m_win[i][p];
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("u%0d scores", i), 32'(sc[i]), 32'(exp_sc(i)));
                chk($sformatf("u%0d point_pulse", i), 32'(pp[i]), 32'(exp_pp(i)));
                chk($sformatf("u%0d winner", i), 32'(wn[i]), 32'(exp_wn(i)));
                chk($sformatf("u%0d game_over", i), 32'(go[i]), 32'(m_over[i]));
            end
        end
    end

    task automatic pulse(input int p, input int gap);
        score_in[p] = 1'b1;
        @(negedge clk);
        score_in[p] = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        score_in = 2'b01;
        reset_n  = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("held input no score", 32'(sc[0]), 32'h0000);
        chk("reset game_over", 32'(go[0]), 32'h0);
        score_in[1] = 1'b1;
        @(negedge clk);
        chk("first point", 32'(sc[0]), 32'h0100);
        chk("first pulse", 32'(pp[0]), 32'h2);
        score_in = 2'b00;
        @(negedge clk);
        chk("pulse one cycle", 32'(pp[0]), 32'h0);
        repeat (6) @(negedge clk);

        repeat (10) pulse(0, 6);
        chk("bcd carry ten", 32'(sc[0]), 32'h0110);
        repeat (9) pulse(1, 6);
        chk("both at ten", 32'(sc[0]), 32'h1010);

        score_in = 2'b11;
        @(negedge clk);
        chk("draw scores", 32'(sc[0]), 32'h1111);
        chk("draw winner", 32'(wn[0]), 32'h3);
        chk("draw game_over", 32'(go[0]), 32'h1);
        chk("endless no winner", 32'(wn[1]), 32'h0);
        score_in = 2'b00;
        @(negedge clk);
        repeat (3) begin
            pulse(0, 6);
            pulse(1, 6);
        end
        chk("over frozen", 32'(sc[0]), 32'h1111);
        chk("over still", 32'(go[0]), 32'h1);

        clear       = 1'b1;
        score_in[0] = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear scores", 32'(sc[0]), 32'h0000);
        chk("clear winner", 32'(wn[0]), 32'h0);
        chk("clear game_over", 32'(go[0]), 32'h0);
        @(negedge clk);
        chk("clear rise dropped", 32'(sc[0]), 32'h0000);
        score_in = 2'b00;
        repeat (6) @(negedge clk);

        enable = 1'b0;
        repeat (5) pulse(0, 2);
        chk("pause scores", 32'(sc[0]), 32'h0000);
        chk("pause pulse", 32'(pp[0]), 32'h0);
        enable = 1'b1;
        repeat (6) @(negedge clk);

        pulse(0, 1);
        pulse(0, 3);
        pulse(0, 0);
        chk("holdoff", 32'(sc[0]), 32'h0002);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        repeat (6) @(negedge clk);

        repeat (99) pulse(0, 5);
        chk("sat at 99", 32'(sc[1]), 32'h0099);
        chk("wrap at 99", 32'(sc[2]), 32'h0099);
        chk("win at 11", 32'(sc[0]), 32'h0011);
        chk("win p0", 32'(wn[0]), 32'h1);
        score_in[0] = 1'b1;
        @(negedge clk);
        chk("sat hold", 32'(sc[1]), 32'h0099);
        chk("sat pulse", 32'(pp[1]), 32'h1);
        chk("wrap zero", 32'(sc[2]), 32'h0000);
        chk("wrap pulse", 32'(pp[2]), 32'h1);
        score_in = 2'b00;
        repeat (6) @(negedge clk);

        repeat (3000) begin
            @(negedge clk);
            score_in = P'($urandom);
            enable   = ($urandom % 10) != 0;
            clear    = ($urandom % 150) == 0;
        end
        clear    = 1'b0;
        score_in = '1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1 chk("async reset", 32'(sc[0]), 32'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset held input", 32'(sc[1]), 32'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Parametrised multi-player BCD score keeper for the Pong datapath; generalises the two-player, two-digit scorer.
- Sits between the ball/collision logic, which produces the score_in pulses, and the seven-segment and VGA digit renderers, which consume the scores bus.
- Adds N players and D BCD digits per player, per-player hold-off, pause, synchronous new-game clear, win detection with a game-over state, and a selectable saturate/wrap overflow mode.

Parameters:
- PLAYERS, 2, number of independent score channels (1..8).
- DIGITS, 2, BCD digits per player (1..4).
- WIN_SCORE, 11, decimal score that ends the game; 0 = endless mode; must be < 10^DIGITS.
- SATURATE, 1, 1 = hold at all-9s on overflow; 0 = wrap to all-0s (endless mode only).
- HOLDOFF, 4, clocks after an accepted point during which that player's further edges are ignored (0 = none).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous new-game request, level-sensitive.
- enable  in  1  1 = play, 0 = paused.
- score_in  in  PLAYERS  per-player score request; a rising edge counts.
- scores  out  PLAYERS*DIGITS*4  BCD scores; player p occupies bits [p*DIGITS*4 +: DIGITS*4]; digit 0 (units) is the LSB nibble.
- point_pulse  out  PLAYERS  one-clock strobe per accepted point.
- winner  out  PLAYERS  one-hot (or multi-hot on a draw) winner flags.
- game_over  out  1  high while in state OVER.

Behaviour:
- Reset (reset_n low, asynchronous):
  - scores = 0, point_pulse = 0, winner = 0, game_over = 0, state = PLAY, hold-off counters = 0.
  - Edge-history registers are set to 1, so an input already high at reset release does not score.
- Edge detect: rise[p] = score_in[p] & ~prev[p]; prev[p] <= score_in[p] every clock in every state, including OVER, while paused, and during hold-off.
- Acceptance: accept[p] = rise[p] & enable & (state == PLAY) & (hold[p] == 0) & ~clear.
  - A rise that is not accepted is dropped, never queued.
- Latency: for an accepted point in cycle k, the incremented score and point_pulse[p] = 1 are both visible after clock edge k (1 clock). point_pulse is registered and lasts one cycle.
- BCD increment: ripple carry, least-significant digit first; a digit at 9 becomes 0 and carries. Digits never hold values 10..15.
- Overflow (all digits at 9 plus an accepted point):
  - SATURATE = 1: score stays at all-9s and point_pulse still fires.
  - SATURATE = 0: score wraps to 0.
- Hold-off: an accepted point loads hold[p] = HOLDOFF; the counter decrements once per clock to 0. Counters are independent per player.
- State machine: two states, PLAY and OVER.
  - PLAY -> OVER: WIN_SCORE != 0 and any player's post-increment score == WIN_SCORE. winner bits for every such player are set on the same edge; game_over rises on that edge.
  - OVER: scores, winner and point_pulse frozen (point_pulse = 0); all edges ignored.
  - OVER -> PLAY: only via clear.
- clear (highest priority after reset): on the next edge scores = 0, winner = 0, hold = 0, point_pulse = 0, state = PLAY. Any same-cycle rise is dropped. prev keeps tracking.
- Simultaneous points:
  - Different players: both increment in the same cycle.
  - Two players reaching WIN_SCORE on the same edge: both winner bits set (draw), game_over = 1.
- Pause: enable = 0 freezes scores; hold-off counters keep decrementing.

Test Plan:
- Release reset with score_in[0] held high, then pulse score_in[1] 0->1 -> scores stays 0x0000 until the pulse; then P1 = 0x01 one clock after the rising edge, point_pulse = 2'b10 for exactly 1 cycle.
- 10 spaced pulses on P0 (gap > HOLDOFF) -> P0 BCD = 0x10, never 0x0A; with WIN_SCORE = 0, SATURATE = 1 and 100 pulses -> P0 = 0x99, and point_pulse still fires on the 100th.
- Same as above with SATURATE = 0 -> P0 = 0x00 after the 100th pulse.
- Two P0 rises 2 cycles apart with HOLDOFF = 4 -> only the first is counted; a third rise 6 cycles after the first is counted (P0 = 0x02).
- WIN_SCORE = 11: P0 at 0x10 and P1 at 0x10, both rise in the same cycle -> scores 0x11/0x11, winner = 2'b11, game_over = 1; further pulses leave all outputs unchanged.
- In OVER, assert clear together with a P0 rise -> next cycle scores = 0, winner = 0, game_over = 0, P0 stays 0; with enable = 0, 5 pulses leave scores at 0 and point_pulse low.
